// File: rtl/alu_pkg.sv
// alu_pkg
// Shared constants and types for the ALU arbiter slice:
//   - ALU_WIDTH : default operand/result width (must match the ALU instance)
//   - OP_*      : ALU opcode encodings; 6 and 7 are illegal
//   - state_e   : arbiter FSM state encoding
//   - helpers   : opcode legality and carry-producing classification
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_EQ  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_EQ);
    endfunction

    // Only the arithmetic ops report a meaningful carry-out.
    function automatic logic op_has_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin grant, purely combinational. The grant pointer
// (last_grant) is owned and updated by the parent.
// Ports:
//   valid0, valid1 : request present from requester 0 / 1
//   last_grant     : index of the requester served most recently
//   gnt_valid      : some requester is granted
//   gnt_id         : index of the granted requester (meaningful when gnt_valid)
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = valid0 | valid1;
        // req1 wins when it is alone, or on a tie when req0 was served last.
        gnt_id    = valid1 & (~valid0 | ~last_grant);
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one ALU between two requesters (0: datapath sequencer,
// 1: branch/compare unit) with round-robin fairness. A granted request's
// operands are registered, driven to the ALU for one execute cycle, and the
// result/flags are captured into a response register held until accepted.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request; grants one and loads its operands
//   EXEC  | operand registers drive the ALU; result captured at the edge
//   RESP  | response held on rsp_*; returns to IDLE on rsp_ready
//
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   reqN_valid/ready              : request handshake, N = 0/1
//   reqN_op/a/b/cin               : request opcode, operands, carry-in
//   alu_x/y/op/cin                : drive to the ALU (held from registers)
//   alu_out/cout/lt/eq/gt         : ALU result and flags
//   rsp_valid/ready               : response handshake
//   rsp_id/data/cout/lt/eq/gt/err : registered response fields
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,

    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    input  logic             alu_lt,
    input  logic             alu_eq,
    input  logic             alu_gt,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_lt,
    output logic             rsp_eq,
    output logic             rsp_gt,
    output logic             rsp_err
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;

    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_lt_q, rsp_lt_d;
    logic             rsp_eq_q, rsp_eq_d;
    logic             rsp_gt_q, rsp_gt_d;
    logic             rsp_err_q, rsp_err_d;

    logic             gnt_valid;
    logic             gnt_id;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_cin;
    logic             grant_now;

    rr_arb2 u_rr_arb2 (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_comb begin
        sel_op  = gnt_id ? req1_op  : req0_op;
        sel_a   = gnt_id ? req1_a   : req0_a;
        sel_b   = gnt_id ? req1_b   : req0_b;
        sel_cin = gnt_id ? req1_cin : req0_cin;
        // Gated by rst_n so ready reads 0 while reset is held, even with
        // requests pending.
        grant_now  = rst_n && (state_q == IDLE) && gnt_valid;
        req0_ready = grant_now && !gnt_id;
        req1_ready = grant_now &&  gnt_id;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_lt_d     = rsp_lt_q;
        rsp_eq_d     = rsp_eq_q;
        rsp_gt_d     = rsp_gt_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    last_grant_d = gnt_id;
                    id_d         = gnt_id;
                    if (op_is_legal(sel_op)) begin
                        op_d    = sel_op;
                        a_d     = sel_a;
                        b_d     = sel_b;
                        cin_d   = sel_cin;
                        state_d = EXEC;
                    end else begin
                        // Illegal ops never reach the ALU, so its inputs keep
                        // their previous values and the error response is
                        // formed directly.
                        rsp_id_d   = gnt_id;
                        rsp_data_d = '0;
                        rsp_cout_d = 1'b0;
                        rsp_lt_d   = 1'b0;
                        rsp_eq_d   = 1'b0;
                        rsp_gt_d   = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            EXEC: begin
                rsp_id_d   = id_q;
                rsp_err_d  = 1'b0;
                rsp_lt_d   = alu_lt;
                rsp_eq_d   = alu_eq;
                rsp_gt_d   = alu_gt;
                rsp_cout_d = op_has_carry(op_q) ? alu_cout : 1'b0;
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: rsp_data_d = alu_out;
                    // The ALU's op-5 result is not fully defined; the equality
                    // result is built from its eq flag instead.
                    OP_EQ:   rsp_data_d = {{(WIDTH-1){1'b0}}, alu_eq};
                    default: rsp_data_d = '0;
                endcase
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_lt_q     <= 1'b0;
            rsp_eq_q     <= 1'b0;
            rsp_gt_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_lt_q     <= rsp_lt_d;
            rsp_eq_q     <= rsp_eq_d;
            rsp_gt_q     <= rsp_gt_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        alu_x     = a_q;
        alu_y     = b_q;
        alu_op    = op_q;
        alu_cin   = cin_q;
        rsp_valid = (state_q == RESP);
        rsp_id    = rsp_id_q;
        rsp_data  = rsp_data_q;
        rsp_cout  = rsp_cout_q;
        rsp_lt    = rsp_lt_q;
        rsp_eq    = rsp_eq_q;
        rsp_gt    = rsp_gt_q;
        rsp_err   = rsp_err_q;
    end

endmodule
